// File: rtl/writeback_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile_pkg
//  Description : Constants, instruction-format codes and decode helpers
//                shared by the writeback stage and its register file.
//                - BIT_WIDTH       : datapath / register width
//                - REG_LR, REG_PC  : architectural indices of LR and PC
//                - PC_READ_OFFSET  : PC read-ahead seen on an R15 read
//                - decode_format, decode_branch_is_link, decode_rd_index
//  Revision    : 1.0  initial release
// ============================================================================
package writeback_regfile_pkg;

  localparam int          BIT_WIDTH      = 32;
  localparam int          REG_ADDR_W     = 4;
  localparam logic [3:0]  REG_LR         = 4'd14;
  localparam logic [3:0]  REG_PC         = 4'd15;
  localparam int          PC_READ_OFFSET = 8;
  localparam int          PC_STEP        = 4;

  typedef enum logic [1:0] {
    FMT_DATA   = 2'd0,
    FMT_MEM    = 2'd1,
    FMT_BRANCH = 2'd2,
    FMT_OTHER  = 2'd3
  } fmt_e;

  // op_hi is instruction bits [27:25].
  function automatic fmt_e decode_format(input logic [2:0] op_hi);
    fmt_e fmt;
    fmt = FMT_OTHER;
    if (op_hi[2:1] == 2'b00)      fmt = FMT_DATA;
    else if (op_hi[2:1] == 2'b01) fmt = FMT_MEM;
    else if (op_hi == 3'b101)     fmt = FMT_BRANCH;
    return fmt;
  endfunction

  // op is instruction bits [27:24]; bit 24 is the link flag of a branch.
  function automatic logic decode_branch_is_link(input logic [3:0] op);
    return (decode_format(op[3:1]) == FMT_BRANCH) && op[0];
  endfunction

  // Branch-with-link always targets LR; everything else uses the Rd field.
  function automatic logic [3:0] decode_rd_index(input logic [3:0] op,
                                                 input logic [3:0] rd_field);
    return decode_branch_is_link(op) ? REG_LR : rd_field;
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_regfile_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : General-purpose register storage, two combinational read
//                ports and one synchronous write port with write-through
//                bypass. Addresses at or beyond NUM_ENTRIES read as zero.
//  Ports       : clk, nreset (sync, active-high)
//                we / waddr / wdata        write port
//                raddr_a / rdata_a         read port A
//                raddr_b / rdata_b         read port B
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r1w #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_ENTRIES = 15
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Full address-space view so the read mux needs no range guard.
  logic [DATA_W-1:0] rd_arr [DEPTH];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    logic [DATA_W-1:0] entry_q;
    logic [DATA_W-1:0] entry_d;

    always_comb begin
      entry_d = entry_q;
      if (we && (waddr == ADDR_W'(i))) entry_d = wdata;
    end

    always_ff @(posedge clk) begin
      if (nreset) entry_q <= '0;
      else        entry_q <= entry_d;
    end

    assign rd_arr[i] = entry_q;
  end

  for (genvar i = NUM_ENTRIES; i < DEPTH; i++) begin : g_unused
    assign rd_arr[i] = '0;
  end

  always_comb begin
    rdata_a = rd_arr[raddr_a];
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    rdata_b = rd_arr[raddr_b];
    if (we && (waddr == raddr_b)) rdata_b = wdata;
  end

endmodule
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile
//  Description : Final pipeline stage. Commits executor results into the
//                architectural register file and the PC, serves the two
//                decoder read ports, drives fetch PC and a one-cycle flush
//                after every redirect, and counts retired writes.
//  Ports       : clk, nreset (sync, active-high)
//                enable, ready              stage handshake
//                pc_advance                 fetch step request (PC += 4)
//                executor_inst              instruction being committed
//                update_Rd / Rd_value       register commit
//                update_pc / new_pc         PC redirect
//                Rn_addr/Rn_value, Rm_addr/Rm_value  decoder read ports
//                pc, flush, retired_count   stage outputs
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_regfile #(
  parameter int                     BIT_WIDTH = 32,
  parameter int                     NUM_REGS  = 16,
  parameter logic [BIT_WIDTH-1:0]   RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 enable,
  output logic                 ready,
  input  logic                 pc_advance,
  input  logic [BIT_WIDTH-1:0] executor_inst,
  input  logic                 update_Rd,
  input  logic [BIT_WIDTH-1:0] Rd_value,
  input  logic                 update_pc,
  input  logic [BIT_WIDTH-1:0] new_pc,
  input  logic [3:0]           Rn_addr,
  input  logic [3:0]           Rm_addr,
  output logic [BIT_WIDTH-1:0] Rn_value,
  output logic [BIT_WIDTH-1:0] Rm_value,
  output logic [BIT_WIDTH-1:0] pc,
  output logic                 flush,
  output logic [BIT_WIDTH-1:0] retired_count
);

  import writeback_regfile_pkg::*;

  logic [3:0]           op_bits;
  logic [3:0]           rd_field;
  logic [3:0]           rd_idx;
  logic                 rd_is_pc;
  logic                 rf_we;
  logic                 redirect;
  logic [BIT_WIDTH-1:0] rf_rn;
  logic [BIT_WIDTH-1:0] rf_rm;
  logic [BIT_WIDTH-1:0] pc_read;

  logic                 ready_q,  ready_d;
  logic                 flush_q,  flush_d;
  logic [BIT_WIDTH-1:0] pc_q,     pc_d;
  logic [BIT_WIDTH-1:0] count_q,  count_d;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{executor_inst[BIT_WIDTH-1:28], executor_inst[23:16],
                              executor_inst[11:0]};

  assign op_bits  = executor_inst[27:24];
  assign rd_field = executor_inst[15:12];
  assign rd_idx   = decode_rd_index(op_bits, rd_field);

  // An Rd write to R15 is a PC write and never reaches the register array.
  assign rd_is_pc = enable && update_Rd && (rd_idx == REG_PC);
  assign rf_we    = enable && update_Rd && (rd_idx != REG_PC);
  assign redirect = (enable && update_pc) || rd_is_pc;

  regfile_2r1w #(
    .DATA_W      (BIT_WIDTH),
    .ADDR_W      (REG_ADDR_W),
    .NUM_ENTRIES (NUM_REGS - 1)
  ) u_regs (
    .clk     (clk),
    .nreset  (nreset),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (Rd_value),
    .raddr_a (Rn_addr),
    .rdata_a (rf_rn),
    .raddr_b (Rm_addr),
    .rdata_b (rf_rm)
  );

  always_comb begin
    ready_d = enable;
    flush_d = redirect;
    count_d = count_q;
    if (enable && (update_Rd || update_pc)) count_d = count_q + BIT_WIDTH'(1);

    // Explicit redirect beats an R15 write, which beats a sequential step.
    pc_d = pc_q;
    if (enable && update_pc) pc_d = new_pc;
    else if (rd_is_pc)       pc_d = Rd_value;
    else if (pc_advance)     pc_d = pc_q + BIT_WIDTH'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      ready_q <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      ready_q <= ready_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign pc_read  = pc_q + BIT_WIDTH'(PC_READ_OFFSET);
  assign Rn_value = (Rn_addr == REG_PC) ? pc_read : rf_rn;
  assign Rm_value = (Rm_addr == REG_PC) ? pc_read : rf_rm;

  assign ready         = ready_q;
  assign flush         = flush_q;
  assign pc            = pc_q;
  assign retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_regfile
//  Description : Directed self-checking bench for writeback_regfile.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_regfile;

  logic        clk;
  logic        nreset;
  logic        enable;
  logic        ready;
  logic        pc_advance;
  logic [31:0] executor_inst;
  logic        update_Rd;
  logic [31:0] Rd_value;
  logic        update_pc;
  logic [31:0] new_pc;
  logic [3:0]  Rn_addr;
  logic [3:0]  Rm_addr;
  logic [31:0] Rn_value;
  logic [31:0] Rm_value;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] retired_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] INST_RD3  = 32'h0000_3000;
  localparam logic [31:0] INST_RD5  = 32'h0000_5000;
  localparam logic [31:0] INST_RD15 = 32'h0000_F000;
  localparam logic [31:0] INST_BL   = 32'h0B00_0000;

  writeback_regfile #(
    .BIT_WIDTH (32),
    .NUM_REGS  (16),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .enable        (enable),
    .ready         (ready),
    .pc_advance    (pc_advance),
    .executor_inst (executor_inst),
    .update_Rd     (update_Rd),
    .Rd_value      (Rd_value),
    .update_pc     (update_pc),
    .new_pc        (new_pc),
    .Rn_addr       (Rn_addr),
    .Rm_addr       (Rm_addr),
    .Rn_value      (Rn_value),
    .Rm_value      (Rm_value),
    .pc            (pc),
    .flush         (flush),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable        = 1'b0;
    pc_advance    = 1'b0;
    executor_inst = '0;
    update_Rd     = 1'b0;
    Rd_value      = '0;
    update_pc     = 1'b0;
    new_pc        = '0;
  endtask

  initial begin
    nreset  = 1'b1;
    Rn_addr = '0;
    Rm_addr = '0;
    idle_inputs();
    tick();
    tick();
    nreset = 1'b0;

    // 1. Reset state.
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_count", retired_count, 32'd0);
    for (int i = 0; i < 15; i++) begin
      Rn_addr = 4'(i);
      Rm_addr = 4'(14 - i);
      #1;
      check($sformatf("rst_rn_R%0d", i), Rn_value, 32'h0);
      check($sformatf("rst_rm_R%0d", 14 - i), Rm_value, 32'h0);
    end
    Rn_addr = 4'd15;
    #1;
    check("rst_r15", Rn_value, 32'h8);

    // 2. Write R3 with same-cycle bypass on both ports.
    enable        = 1'b1;
    update_Rd     = 1'b1;
    executor_inst = INST_RD3;
    Rd_value      = 32'hDEAD_BEEF;
    Rn_addr       = 4'd3;
    Rm_addr       = 4'd3;
    #1;
    check("bypass_rn", Rn_value, 32'hDEAD_BEEF);
    check("bypass_rm", Rm_value, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    #1;
    check("r3_stored", Rn_value, 32'hDEAD_BEEF);
    check("count_1", retired_count, 32'd1);
    check("ready_1", {31'd0, ready}, 32'd1);
    check("flush_rd", {31'd0, flush}, 32'd0);
    tick();
    check("ready_0", {31'd0, ready}, 32'd0);

    // 3. Sequential advance, then redirect that beats pc_advance.
    pc_advance = 1'b1;
    tick();
    tick();
    tick();
    check("pc_adv3", pc, 32'd12);
    enable    = 1'b1;
    update_pc = 1'b1;
    new_pc    = 32'h100;
    tick();
    idle_inputs();
    check("pc_redir", pc, 32'h100);
    check("flush_hi", {31'd0, flush}, 32'd1);
    check("count_2", retired_count, 32'd2);
    Rm_addr = 4'd15;
    #1;
    check("r15_read", Rm_value, 32'h108);
    tick();
    check("flush_lo", {31'd0, flush}, 32'd0);
    check("pc_hold", pc, 32'h100);

    // 4. BL at 0x20: LR write and redirect in one commit.
    enable    = 1'b1;
    update_pc = 1'b1;
    new_pc    = 32'h20;
    tick();
    idle_inputs();
    tick();
    check("pc_0x20", pc, 32'h20);
    check("count_3", retired_count, 32'd3);
    enable        = 1'b1;
    update_pc     = 1'b1;
    new_pc        = 32'h80;
    update_Rd     = 1'b1;
    executor_inst = INST_BL;
    Rd_value      = 32'h24;
    tick();
    idle_inputs();
    Rn_addr = 4'd14;
    #1;
    check("bl_lr", Rn_value, 32'h24);
    check("bl_pc", pc, 32'h80);
    check("bl_count", retired_count, 32'd4);
    check("bl_flush", {31'd0, flush}, 32'd1);
    tick();

    // 5. Rd==15 write is a PC write; update_pc wins when both occur.
    enable        = 1'b1;
    update_Rd     = 1'b1;
    executor_inst = INST_RD15;
    Rd_value      = 32'h40;
    tick();
    idle_inputs();
    check("rd15_pc", pc, 32'h40);
    check("rd15_flush", {31'd0, flush}, 32'd1);
    check("rd15_count", retired_count, 32'd5);
    tick();
    check("rd15_flush_lo", {31'd0, flush}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      Rn_addr = 4'(i);
      #1;
      check($sformatf("rd15_keep_R%0d", i), Rn_value,
            (i == 3) ? 32'hDEAD_BEEF : ((i == 14) ? 32'h24 : 32'h0));
    end
    enable        = 1'b1;
    update_Rd     = 1'b1;
    executor_inst = INST_RD15;
    Rd_value      = 32'h40;
    update_pc     = 1'b1;
    new_pc        = 32'h60;
    tick();
    idle_inputs();
    check("prio_pc", pc, 32'h60);
    check("prio_count", retired_count, 32'd6);
    tick();

    // 6. Reset during a commit drops the write.
    nreset        = 1'b1;
    enable        = 1'b1;
    update_Rd     = 1'b1;
    executor_inst = INST_RD5;
    Rd_value      = 32'h7;
    pc_advance    = 1'b1;
    tick();
    nreset = 1'b0;
    idle_inputs();
    Rn_addr = 4'd5;
    Rm_addr = 4'd3;
    #1;
    check("rstc_r5", Rn_value, 32'h0);
    check("rstc_r3", Rm_value, 32'h0);
    check("rstc_pc", pc, 32'h0);
    check("rstc_count", retired_count, 32'd0);
    check("rstc_ready", {31'd0, ready}, 32'd0);
    check("rstc_flush", {31'd0, flush}, 32'd0);
    update_Rd     = 1'b1;
    executor_inst = INST_RD5;
    Rd_value      = 32'h7;
    #1;
    check("noen_bypass", Rn_value, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("noen_r5", Rn_value, 32'h0);
    check("noen_count", retired_count, 32'd0);
    check("noen_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
